fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch controller that drives the instruction memory address port, waits a fixed number of cycles for the combinational read to settle, latches the fetched word with its PC, and hands it to decode over a valid/ready handshake. It owns the program counter, supports branch/jump redirect, and raises `done` when the PC runs past the loaded program. It sits between the instruction memory and the decode stage.

## Interface
- `RD_CYCLES`, default 2: clock cycles allowed for an instruction memory read; legal range 1..255.
- `MEM_SIZE`, default 40: program size in bytes; fetch stops once PC >= MEM_SIZE.
- `RESET_PC`, default 0: PC loaded at reset and used by `start`.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins fetching at `RESET_PC`; honoured only in IDLE.
- `imem_addr`  out  32  address to instruction memory; always equals the PC register.
- `imem_instr`  in  32  instruction word returned by memory.
- `instr`  out  32  latched instruction for decode.
- `instr_pc`  out  32  byte address `instr` was fetched from.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a fetched instruction.
- `instr_ready`  in  1  decode accepts; a transfer occurs on a cycle with valid & ready.
- `redirect`  in  1  branch/jump taken; restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  redirect target; bits [1:0] are forced to 0.
- `done`  out  1  PC has reached `MEM_SIZE`; fetch halted.

## Operation
- Reset values: state IDLE, pc = `RESET_PC`, cnt = 0, `instr` = 0, `instr_pc` = 0, `instr_valid` = 0, `done` = 0. A reset in any state, including mid-read, wins over every other input.
- States and transitions:
  - **IDLE**: if `start` is high, go to WAIT with pc = `RESET_PC` and cnt = 0.
  - **WAIT**: while cnt != `RD_CYCLES`-1, cnt increments. When cnt == `RD_CYCLES`-1, the block latches `instr` <= `imem_instr`, `instr_pc` <= pc, `instr_valid` <= 1, pc <= pc+4, and goes to VALID.
  - **VALID**: outputs are held stable. On a handshake, `instr_valid` <= 0. The block then goes to DONE with `done` <= 1 if pc >= `MEM_SIZE`; otherwise it goes to WAIT with cnt = 0.
  - **DONE**: stays there; only `reset` or `redirect` leaves it.
- Redirect:
  - `redirect` is honoured in every state, IDLE and DONE included.
  - On a redirect: pc <= {`redirect_pc`[31:2], 2'b00}, cnt <= 0, `instr_valid` <= 0, `done` <= 0, next state WAIT.
  - Any in-flight read is discarded.
  - Redirect takes priority over `start` and over a same-cycle handshake. Decode treats the word presented on that cycle as accepted.
- `start` outside IDLE is ignored.
- PC arithmetic is modulo 2^32. The `MEM_SIZE` comparison is unsigned.

## Timing
- `imem_addr` is registered and changes only on the edge that updates pc.
- `instr_valid` rises `RD_CYCLES` edges after the edge that enters WAIT.
- Throughput with `instr_ready` held high: one instruction every `RD_CYCLES`+1 cycles, because the handshake edge re-enters WAIT.
- Backpressure: while in VALID with `instr_ready` low, `instr`, `instr_pc`, `imem_addr` and pc do not change.
- `done` rises on the handshake edge of the last instruction and stays high until reset or redirect.

## Structure
- The shared processor package holds:
  - the state enum (IDLE, WAIT, VALID, DONE),
  - `INSTR_W` = 32,
  - `PC_STEP` = 4.
- The read-wait counter is 8 bits and lives inline. This is a single module; no sub-module is warranted.

## Test plan
- Linear run with `MEM_SIZE`=20, `RD_CYCLES`=2, ready held high:
  - Stimulus: `start` pulse.
  - Required: five transfers with `instr_pc` = 0, 4, 8, 12, 16, 3 cycles apart, `instr` matching the memory contents.
  - Required: `done`=1 after the fifth transfer, and `imem_addr` stays at 20.
- Backpressure: drop `instr_ready` for 4 cycles while `instr_pc`=8.
  - Required: `instr`, `instr_pc`=8 and `imem_addr`=12 are stable.
  - Required: exactly one transfer follows when ready rises.
- Redirect in WAIT: `redirect` with `redirect_pc`=0x0000000E, one cycle after entering WAIT for PC 4.
  - Required: no valid is produced for PC 4.
  - Required: `imem_addr`=0xC and the next transfer has `instr_pc`=0xC.
- Redirect in VALID with ready high on the same cycle, `redirect_pc`=0:
  - Required: `instr_valid` falls.
  - Required: the next transfer has `instr_pc`=0 and `done` stays 0.
- Reset mid-WAIT:
  - Required: next cycle shows state IDLE, `imem_addr`=`RESET_PC`, and all outputs at their reset values.
  - Required: `start` then refetches from 0.
- `RD_CYCLES`=1 with `MEM_SIZE`=8:
  - Required: transfers 2 cycles apart, then `done`.
  - Then: `redirect` to 0 in DONE clears `done` and refetches PC 0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: fetch-stage state encoding and word/PC constants
package fetch_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, VALID, DONE} state_t;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction memory, decode handshake and control signals of the fetch stage
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;
    logic               start;
    logic [INSTR_W-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect;
    logic [INSTR_W-1:0] redirect_pc;
    logic               done;
    modport master (
        input  start, imem_instr, instr_ready, redirect, redirect_pc,
        output imem_addr, instr, instr_pc, instr_valid, done
    );
    modport slave (
        output start, imem_instr, instr_ready, redirect, redirect_pc,
        input  imem_addr, instr, instr_pc, instr_valid, done
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, waits out the memory read, and hands fetched words to decode
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                 RD_CYCLES = 2,
    parameter int                 MEM_SIZE  = 40,
    parameter logic [INSTR_W-1:0] RESET_PC  = '0
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);
    state_t             state, state_n;
    logic [INSTR_W-1:0] pc, pc_n, instr_n, instr_pc_n;
    logic [7:0]         cnt, cnt_n;
    logic               valid_n, done_n;

    assign bus.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            cnt             <= '0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            cnt             <= cnt_n;
            bus.instr       <= instr_n;
            bus.instr_pc    <= instr_pc_n;
            bus.instr_valid <= valid_n;
            bus.done        <= done_n;
        end
    end

    // redirect overrides start and a same-cycle handshake; an in-flight read is dropped
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        cnt_n      = cnt;
        instr_n    = bus.instr;
        instr_pc_n = bus.instr_pc;
        valid_n    = bus.instr_valid;
        done_n     = bus.done;
        if (bus.redirect) begin
            pc_n    = {bus.redirect_pc[INSTR_W-1:2], 2'b00};
            cnt_n   = '0;
            valid_n = 1'b0;
            done_n  = 1'b0;
            state_n = WAIT;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state_n = WAIT;
                    pc_n    = RESET_PC;
                    cnt_n   = '0;
                end
                WAIT: if (cnt == 8'(RD_CYCLES - 1)) begin
                    instr_n    = bus.imem_instr;
                    instr_pc_n = pc;
                    valid_n    = 1'b1;
                    pc_n       = pc + INSTR_W'(PC_STEP);
                    state_n    = VALID;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
                VALID: if (bus.instr_ready) begin
                    valid_n = 1'b0;
                    cnt_n   = '0;
                    done_n  = pc >= INSTR_W'(MEM_SIZE);
                    state_n = (pc >= INSTR_W'(MEM_SIZE)) ? DONE : WAIT;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for two fetch_sequencer configurations
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_a = 0;
    int   last_b = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    fetch_sequencer_if ia();
    fetch_sequencer_if ib();

    fetch_sequencer #(.RD_CYCLES(2), .MEM_SIZE(20)) dut_a (.clk(clk), .reset(rst), .bus(ia));
    fetch_sequencer #(.RD_CYCLES(1), .MEM_SIZE(8))  dut_b (.clk(clk), .reset(rst), .bus(ib));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // word at address a is base + a/4
    assign ia.imem_instr = 32'hCAFE0000 + {24'd0, ia.imem_addr[9:2]};
    assign ib.imem_instr = 32'hB0000000 + {24'd0, ib.imem_addr[9:2]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] pc, input int gap);
        qa.push_back('{pc, 32'hCAFE0000 + (pc >> 2), gap});
    endtask

    task automatic push_b(input logic [31:0] pc, input int gap);
        qb.push_back('{pc, 32'hB0000000 + (pc >> 2), gap});
    endtask

    always @(negedge clk) begin
        if (ia.instr_valid && ia.instr_ready) begin
            if (qa.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL a_extra transfer actual pc=%h required none", ia.instr_pc);
            end else begin
                ea = qa.pop_front();
                check("a_pc", ia.instr_pc, ea.pc);
                check("a_instr", ia.instr, ea.word);
                if (ea.gap != 0) check("a_gap", 32'(cyc - last_a), 32'(ea.gap));
            end
            last_a = cyc;
        end
    end

    always @(negedge clk) begin
        if (ib.instr_valid && ib.instr_ready) begin
            if (qb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL b_extra transfer actual pc=%h required none", ib.instr_pc);
            end else begin
                eb = qb.pop_front();
                check("b_pc", ib.instr_pc, eb.pc);
                check("b_instr", ib.instr, eb.word);
                if (eb.gap != 0) check("b_gap", 32'(cyc - last_b), 32'(eb.gap));
            end
            last_b = cyc;
        end
    end

    task automatic wait_a(input logic [31:0] pc, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = ia.instr_valid && ia.instr_pc == pc;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input bit sel, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = sel ? ib.done : ia.done;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic redir(input bit sel, input logic [31:0] pc);
        if (sel) begin ib.redirect = 1'b1; ib.redirect_pc = pc; end
        else     begin ia.redirect = 1'b1; ia.redirect_pc = pc; end
        @(posedge clk);
        #1;
        ia.redirect = 1'b0;
        ib.redirect = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) ib.start = 1'b1; else ia.start = 1'b1;
        @(posedge clk);
        #1;
        ia.start = 1'b0;
        ib.start = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_state"}, 32'(dut_a.state), 32'(IDLE));
        check({tag, "_addr"}, ia.imem_addr, 32'd0);
        check({tag, "_instr"}, ia.instr, 32'd0);
        check({tag, "_ipc"}, ia.instr_pc, 32'd0);
        check({tag, "_valid"}, 32'(ia.instr_valid), 32'd0);
        check({tag, "_done"}, 32'(ia.done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ia.start = 1'b0; ia.instr_ready = 1'b1; ia.redirect = 1'b0; ia.redirect_pc = '0;
        ib.start = 1'b0; ib.instr_ready = 1'b1; ib.redirect = 1'b0; ib.redirect_pc = '0;
        repeat (2) @(negedge clk);
        check_reset_a("rst");
        @(posedge clk);
        #1 rst = 1'b0;

        // linear run: 0..16, three cycles apart, then done with addr parked at 20
        for (int i = 0; i < 5; i++) push_a(32'(i * 4), i == 0 ? 0 : 3);
        pulse_start(1'b0);
        wait_done(1'b0, "lin_done");
        check("lin_addr", ia.imem_addr, 32'd20);
        repeat (3) @(negedge clk);
        check("lin_addr_hold", ia.imem_addr, 32'd20);
        check("lin_valid_low", 32'(ia.instr_valid), 32'd0);
        check("lin_drained", 32'(qa.size()), 32'd0);

        // backpressure on pc 8
        push_a(32'd0, 0);
        push_a(32'd4, 3);
        redir(1'b0, 32'd0);
        @(negedge clk);
        check("bp_done_clr", 32'(ia.done), 32'd0);
        check("bp_addr0", ia.imem_addr, 32'd0);
        wait_a(32'd4, "bp_seen4");
        @(posedge clk);
        #1 ia.instr_ready = 1'b0;
        wait_a(32'd8, "bp_seen8");
        for (int i = 0; i < 4; i++) begin
            check("bp_ipc", ia.instr_pc, 32'd8);
            check("bp_instr", ia.instr, 32'hCAFE0002);
            check("bp_addr", ia.imem_addr, 32'd12);
            check("bp_valid", 32'(ia.instr_valid), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        push_a(32'd8, 0);
        push_a(32'd12, 3);
        push_a(32'd16, 3);
        @(posedge clk);
        #1 ia.instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_single", 32'(ia.instr_valid), 32'd0);
        wait_done(1'b0, "bp_done");

        // redirect to 0xE one cycle into the wait for pc 4
        push_a(32'd0, 0);
        push_a(32'hC, 4);
        push_a(32'h10, 3);
        redir(1'b0, 32'd0);
        wait_a(32'd0, "rw_seen0");
        @(posedge clk);
        #1 redir(1'b0, 32'h0000000E);
        @(negedge clk);
        check("rw_addr", ia.imem_addr, 32'hC);
        check("rw_valid", 32'(ia.instr_valid), 32'd0);
        wait_done(1'b0, "rw_done");

        // redirect to 0 on a VALID cycle that also handshakes
        push_a(32'd0, 0);
        redir(1'b0, 32'd0);
        wait_a(32'd0, "rv_seen0");
        ia.redirect = 1'b1;
        ia.redirect_pc = 32'd0;
        for (int i = 0; i < 5; i++) push_a(32'(i * 4), 3);
        @(posedge clk);
        #1 ia.redirect = 1'b0;
        @(negedge clk);
        check("rv_valid_fall", 32'(ia.instr_valid), 32'd0);
        check("rv_done", 32'(ia.done), 32'd0);
        check("rv_addr", ia.imem_addr, 32'd0);
        wait_done(1'b0, "rv_done_end");

        // reset in the middle of a read
        redir(1'b0, 32'd8);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_a("mid");
        repeat (2) @(negedge clk);
        check("mid_idle_addr", ia.imem_addr, 32'd0);
        for (int i = 0; i < 5; i++) push_a(32'(i * 4), i == 0 ? 0 : 3);
        pulse_start(1'b0);
        wait_done(1'b0, "mid_done");
        check("a_drained", 32'(qa.size()), 32'd0);

        // single-cycle reads, small program, then redirect out of DONE
        push_b(32'd0, 0);
        push_b(32'd4, 2);
        pulse_start(1'b1);
        wait_done(1'b1, "b_done");
        check("b_addr", ib.imem_addr, 32'd8);
        push_b(32'd0, 0);
        push_b(32'd4, 2);
        redir(1'b1, 32'd0);
        @(negedge clk);
        check("b_done_clr", 32'(ib.done), 32'd0);
        check("b_addr0", ib.imem_addr, 32'd0);
        wait_done(1'b1, "b_done2");
        check("b_drained", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
